// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The starvation feature is selected with the DMEM_ARB_STARVE_EN macro in dmem_arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    // Side that owns the read data returning from dmem next cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        EXT  = 2'd2
    } rd_owner_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating refusal counter for the EXT port; sat forces EXT ahead of the CPU.
// Instantiated by dmem_arbiter only when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [3:0] r_cnt;

    assign sat = (r_cnt == 4'(STARVE_MAX));

    // clr wins over inc so a grant in the saturated cycle restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !sat) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-cycle arbiter sharing dmem between the CPU MEM stage and one EXT requester.
// Define DMEM_ARB_STARVE_EN to bound EXT waiting; otherwise the CPU has strict priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [2:0]        ext_funct3,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
        $error("dmem_arbiter: STARVE_MAX must be in 1..15");
    end

    logic      w_cpu_req;
    logic      w_ext_force;
    logic      w_ext_gnt;
    logic      w_cpu_gnt;
    rd_owner_t r_rd_owner;
    rd_owner_t w_rd_owner_nxt;

    assign w_cpu_req = cpu_re | cpu_we;

`ifdef DMEM_ARB_STARVE_EN
    logic w_sat;
    logic w_inc;

    assign w_inc       = ext_req & ~w_ext_gnt;
    assign w_ext_force = w_sat;

    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc),
        .clr   (~w_inc),
        .sat   (w_sat)
    );
`else
    assign w_ext_force = 1'b0;
`endif

    // All grants are masked while reset is high so dmem never sees a strobe
    assign w_ext_gnt = ~reset & ext_req & (~w_cpu_req | w_ext_force);
    assign w_cpu_gnt = ~reset & w_cpu_req & ~w_ext_gnt;

    assign ext_gnt   = w_ext_gnt;
    assign cpu_stall = ~reset & w_cpu_req & ~w_cpu_gnt;

    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (w_ext_gnt) begin
            mem_re     = ~ext_we;
            mem_we     = ext_we;
            mem_funct3 = ext_funct3;
            mem_addr   = ext_addr;
            mem_wdata  = ext_wdata;
        end else if (w_cpu_gnt) begin
            mem_re     = cpu_re;
            mem_we     = cpu_we;
            mem_funct3 = cpu_funct3;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
        end
    end

    always_comb begin
        w_rd_owner_nxt = NONE;
        if (w_ext_gnt && !ext_we) begin
            w_rd_owner_nxt = EXT;
        end else if (w_cpu_gnt && cpu_re) begin
            w_rd_owner_nxt = CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_owner <= NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    assign cpu_rvalid = (r_rd_owner == CPU);
    assign ext_rvalid = (r_rd_owner == EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule
